// File: rtl/frame_enc_pkg.sv
// Shared types, palette and angle helpers for the multi-car frame encoder.
// Angles are signed degrees; valid input range is one turn either side of [0,360).
package frame_enc_pkg;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int ANGLE_FULL = 360;

    localparam rgb565_t PALETTE [16] = '{
        16'h0000, 16'hF800, 16'h07E0, 16'h001F,
        16'hFFE0, 16'hF81F, 16'h07FF, 16'hFFFF,
        16'h8000, 16'h0400, 16'h0010, 16'h8410,
        16'hC618, 16'hFC00, 16'h4208, 16'h2104
    };

    function automatic logic angle_ok(input logic signed [31:0] a);
        return (a >= -ANGLE_FULL) && (a < 2 * ANGLE_FULL);
    endfunction

    function automatic logic signed [31:0] angle_norm(input logic signed [31:0] a);
        if (a < 0)
            return a + ANGLE_FULL;
        else if (a >= ANGLE_FULL)
            return a - ANGLE_FULL;
        else
            return a;
    endfunction

    function automatic int angle_bank(input logic signed [31:0] norm, input int steps);
        return (int'(norm) * steps) / ANGLE_FULL;
    endfunction

endpackage

// File: rtl/car_sprite_hit.sv
// Per-car hit test of the current scan pixel against one sprite box, plus ROM address.
// Purely combinational; the address reads zero when the pixel misses the sprite.
module car_sprite_hit
    import frame_enc_pkg::*;
#(
    parameter int SPRITE      = 60,
    parameter int ANGLE_STEPS = 8,
    parameter int BW          = 3,
    parameter int SA          = 15
) (
    input  logic [15:0]   px,
    input  logic [15:0]   py,
    input  logic [15:0]   cx,
    input  logic [15:0]   cy,
    input  logic [BW-1:0] bank,
    output logic          hit,
    output logic [SA-1:0] addr
);

    localparam logic [SA-1:0] BANK_SIZE = SA'(SPRITE * SPRITE);
    localparam logic [SA-1:0] ROW_SIZE  = SA'(SPRITE);

    logic [16:0] dx;
    logic [16:0] dy;
    logic [SA-1:0] lin;

    // 17-bit subtract: a pixel left of/above the sprite gives a huge value, never a wrap hit
    assign dx  = {1'b0, px} - {1'b0, cx};
    assign dy  = {1'b0, py} - {1'b0, cy};
    assign hit = (dx < 17'(SPRITE)) && (dy < 17'(SPRITE));
    assign lin = SA'(bank) * BANK_SIZE + SA'(dy) * ROW_SIZE + SA'(dx);
    assign addr = hit ? lin : '0;

endmodule

// File: rtl/frame_encoder_multi.sv
// Renders one frame of N_CARS rotated sprites over a background, streaming RGB565 in raster order.
// First write 3 cycles after the start edge, then 1 pixel/cycle; a write stall freezes the whole pipeline.
module frame_encoder_multi
    import frame_enc_pkg::*;
#(
    parameter int WIDTH       = 1600,
    parameter int HEIGHT      = 900,
    parameter int N_CARS      = 2,
    parameter int SPRITE      = 60,
    parameter int ANGLE_STEPS = 8,
    parameter int AW          = 20,
    localparam int SA         = $clog2(ANGLE_STEPS * SPRITE * SPRITE)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [15:0]          i_bg_color,
    input  logic [N_CARS*16-1:0] i_car_x,
    input  logic [N_CARS*16-1:0] i_car_y,
    input  logic [N_CARS*32-1:0] i_car_angle,
    output logic [N_CARS*SA-1:0] o_spr_addr,
    input  logic [N_CARS*4-1:0]  i_spr_data,
    output logic [AW-1:0]        o_sram_addr,
    output logic [15:0]          o_sram_data,
    output logic                 o_sram_we,
    input  logic                 i_sram_ready,
    output logic [31:0]          o_proc_counter,
    output logic [31:0]          o_pixel_counter,
    output logic                 o_opacity,
    output logic                 o_opacity_valid,
    output logic                 o_angle_err,
    output logic                 o_done
);

    localparam int BW = (ANGLE_STEPS > 1) ? $clog2(ANGLE_STEPS) : 1;
    localparam logic [15:0] LAST_X = 16'(WIDTH - 1);
    localparam logic [15:0] LAST_Y = 16'(HEIGHT - 1);

    state_e state, state_nxt;
    logic start_q;

    rgb565_t       bg_q;
    logic [15:0]   cx_q   [N_CARS];
    logic [15:0]   cy_q   [N_CARS];
    logic [BW-1:0] bank_q [N_CARS];
    logic [BW-1:0] bank_in[N_CARS];
    logic [N_CARS-1:0] ang_bad;
    logic err_q;

    logic [15:0]   x_cnt, y_cnt;
    logic [AW-1:0] pix_addr;
    logic          last_pix, adv, busy;
    logic [N_CARS-1:0] hit;

    logic              s1_vld;
    logic [N_CARS-1:0] s1_hit;
    logic [AW-1:0]     s1_addr;

    logic                stalled_q;
    logic [N_CARS*4-1:0] hold_dat, spr_cur;
    logic                win_found;
    logic [3:0]          win_dat;
    rgb565_t             pix;

    assign adv      = !o_sram_we || i_sram_ready;
    assign busy     = (state == RUN) || (state == DRAIN);
    assign last_pix = (x_cnt == LAST_X) && (y_cnt == LAST_Y);

    assign o_opacity_valid = o_sram_we;
    assign o_angle_err     = err_q;
    assign o_done          = (state == DONE);

    for (genvar c = 0; c < N_CARS; c++) begin : g_car
        car_sprite_hit #(
            .SPRITE     (SPRITE),
            .ANGLE_STEPS(ANGLE_STEPS),
            .BW         (BW),
            .SA         (SA)
        ) u_hit (
            .px  (x_cnt),
            .py  (y_cnt),
            .cx  (cx_q[c]),
            .cy  (cy_q[c]),
            .bank(bank_q[c]),
            .hit (hit[c]),
            .addr(o_spr_addr[c*SA +: SA])
        );
    end

    always_comb begin
        for (int c = 0; c < N_CARS; c++) begin
            ang_bad[c] = !angle_ok(i_car_angle[c*32 +: 32]);
            bank_in[c] = ang_bad[c] ? '0
                       : BW'(angle_bank(angle_norm(i_car_angle[c*32 +: 32]), ANGLE_STEPS));
        end
    end

    // ROM keeps reading the frozen scan address during a stall, so the word
    // belonging to the stage-1 pixel is parked in hold_dat until the stall clears.
    always_comb begin
        spr_cur   = stalled_q ? hold_dat : i_spr_data;
        win_found = 1'b0;
        win_dat   = 4'd0;
        for (int c = N_CARS - 1; c >= 0; c--) begin
            if (s1_hit[c] && (spr_cur[c*4 +: 4] != 4'd0)) begin
                win_found = 1'b1;
                win_dat   = spr_cur[c*4 +: 4];
            end
        end
        pix = win_found ? PALETTE[win_dat] : bg_q;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start && !start_q) state_nxt = LATCH;
            LATCH:   state_nxt = RUN;
            RUN:     if (adv && last_pix) state_nxt = DRAIN;
            DRAIN:   if (!s1_vld && o_sram_we && i_sram_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            start_q         <= 1'b0;
            bg_q            <= '0;
            err_q           <= 1'b0;
            x_cnt           <= '0;
            y_cnt           <= '0;
            pix_addr        <= '0;
            s1_vld          <= 1'b0;
            s1_hit          <= '0;
            s1_addr         <= '0;
            stalled_q       <= 1'b0;
            hold_dat        <= '0;
            o_sram_we       <= 1'b0;
            o_sram_addr     <= '0;
            o_sram_data     <= '0;
            o_opacity       <= 1'b0;
            o_proc_counter  <= '0;
            o_pixel_counter <= '0;
            for (int c = 0; c < N_CARS; c++) begin
                cx_q[c]   <= '0;
                cy_q[c]   <= '0;
                bank_q[c] <= '0;
            end
        end else begin
            start_q   <= i_start;
            stalled_q <= busy && !adv;
            if (!stalled_q) hold_dat <= i_spr_data;
            if (busy) o_proc_counter <= o_proc_counter + 32'd1;
            if (o_sram_we && i_sram_ready) o_pixel_counter <= o_pixel_counter + 32'd1;

            if (state == LATCH) begin
                bg_q            <= i_bg_color;
                err_q           <= |ang_bad;
                x_cnt           <= '0;
                y_cnt           <= '0;
                pix_addr        <= '0;
                s1_vld          <= 1'b0;
                o_sram_we       <= 1'b0;
                o_proc_counter  <= '0;
                o_pixel_counter <= '0;
                for (int c = 0; c < N_CARS; c++) begin
                    cx_q[c]   <= i_car_x[c*16 +: 16];
                    cy_q[c]   <= i_car_y[c*16 +: 16];
                    bank_q[c] <= bank_in[c];
                end
            end else if (busy && adv) begin
                s1_vld      <= (state == RUN);
                s1_hit      <= hit;
                s1_addr     <= pix_addr;
                o_sram_we   <= s1_vld;
                o_sram_addr <= s1_addr;
                o_sram_data <= pix;
                o_opacity   <= s1_vld && win_found;
                if ((state == RUN) && !last_pix) begin
                    pix_addr <= pix_addr + 1'b1;
                    if (x_cnt == LAST_X) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + 16'd1;
                    end else begin
                        x_cnt <= x_cnt + 16'd1;
                    end
                end
            end else if (!busy) begin
                o_sram_we <= 1'b0;
                o_opacity <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_encoder_multi.sv
// Directed bench for frame_encoder_multi on an 8x4 frame with 4x4 sprites and a 1-cycle sprite ROM.
module tb_frame_encoder_multi;

    localparam logic [15:0] P1 = 16'hF800;
    localparam logic [15:0] P2 = 16'h07E0;
    localparam logic [15:0] P3 = 16'h001F;
    localparam logic [15:0] P4 = 16'hFFE0;
    localparam logic [15:0] P5 = 16'hF81F;
    localparam logic [15:0] P7 = 16'hFFFF;
    localparam logic [15:0] BG = 16'h0841;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_bg_color = BG;
    logic [31:0] i_car_x = '0;
    logic [31:0] i_car_y = '0;
    logic [63:0] i_car_angle = '0;
    logic [13:0] o_spr_addr;
    logic [7:0]  i_spr_data = '0;
    logic [19:0] o_sram_addr;
    logic [15:0] o_sram_data;
    logic        o_sram_we;
    logic        i_sram_ready = 1'b1;
    logic [31:0] o_proc_counter;
    logic [31:0] o_pixel_counter;
    logic        o_opacity;
    logic        o_opacity_valid;
    logic        o_angle_err;
    logic        o_done;

    frame_encoder_multi #(
        .WIDTH(8), .HEIGHT(4), .N_CARS(2), .SPRITE(4), .ANGLE_STEPS(8), .AW(20)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_bg_color(i_bg_color),
        .i_car_x(i_car_x), .i_car_y(i_car_y), .i_car_angle(i_car_angle),
        .o_spr_addr(o_spr_addr), .i_spr_data(i_spr_data),
        .o_sram_addr(o_sram_addr), .o_sram_data(o_sram_data), .o_sram_we(o_sram_we),
        .i_sram_ready(i_sram_ready), .o_proc_counter(o_proc_counter),
        .o_pixel_counter(o_pixel_counter), .o_opacity(o_opacity),
        .o_opacity_valid(o_opacity_valid), .o_angle_err(o_angle_err), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // ROM model: mode 0 returns a fixed index per car, mode 1 returns column+1
    logic       rom_mode = 1'b0;
    logic [3:0] rom_val0 = 4'd0;
    logic [3:0] rom_val1 = 4'd0;
    always @(posedge clk) begin
        i_spr_data[3:0] <= rom_mode ? {2'b00, o_spr_addr[1:0]} + 4'd1 : rom_val0;
        i_spr_data[7:4] <= rom_mode ? {2'b00, o_spr_addr[8:7]} + 4'd1 : rom_val1;
    end

    int total = 0;
    int bad = 0;

    logic [19:0] wr_addr [$];
    logic [15:0] wr_data [$];
    logic        wr_op   [$];
    int   done_cnt, done_cyc, first_we, hold_cnt, opv_bad, rst_cyc;
    logic [6:0] spr0, spr1;
    logic post_rst_any;

    function automatic logic outs_or();
        return |{o_spr_addr, o_sram_addr, o_sram_data, o_sram_we, o_proc_counter,
                 o_pixel_counter, o_opacity, o_opacity_valid, o_angle_err, o_done};
    endfunction

    function automatic logic [15:0] pal(input int idx);
        case (idx)
            1: return P1;
            2: return P2;
            3: return P3;
            4: return P4;
            5: return P5;
            7: return P7;
            default: return 16'hDEAD;
        endcase
    endfunction

    // Starts a frame and records every accepted write; stall/reset keyed on the shown address.
    task automatic run_frame(input int stall_at, input int rst_at, input int hold, input int ncyc);
        int stalls = 0;
        wr_addr.delete(); wr_data.delete(); wr_op.delete();
        done_cnt = 0; done_cyc = -1; first_we = -1; hold_cnt = 0; opv_bad = 0;
        rst_cyc = -1; post_rst_any = 1'b1; spr0 = 7'h7F; spr1 = 7'h7F;
        @(negedge clk);
        i_start = 1'b1;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            if (cyc + 1 >= hold) i_start = 1'b0;
            if (cyc == 1) begin
                spr0 = o_spr_addr[6:0];
                spr1 = o_spr_addr[13:7];
            end
            if (rst_cyc >= 0 && cyc == rst_cyc + 1) post_rst_any = outs_or();
            if (o_done) begin done_cnt++; done_cyc = cyc; end
            if (o_opacity_valid !== o_sram_we) opv_bad++;
            if (o_sram_we && first_we < 0) first_we = cyc;
            i_sram_ready = 1'b1;
            if (o_sram_we && o_sram_addr == stall_at) begin
                hold_cnt++;
                if (stalls < 3) begin i_sram_ready = 1'b0; stalls++; end
            end
            if (o_sram_we && i_sram_ready) begin
                wr_addr.push_back(o_sram_addr);
                wr_data.push_back(o_sram_data);
                wr_op.push_back(o_opacity);
            end
            i_rst = 1'b0;
            if (rst_at >= 0 && rst_cyc < 0 && o_sram_we && o_sram_addr == rst_at) begin
                i_rst = 1'b1;
                rst_cyc = cyc;
            end
        end
        i_rst = 1'b0;
        i_sram_ready = 1'b1;
    endtask

    task automatic set_cars(input logic [15:0] x0, input logic [15:0] y0, input int a0,
                            input logic [15:0] x1, input logic [15:0] y1, input int a1);
        i_car_x = {x1, x0};
        i_car_y = {y1, y0};
        i_car_angle = {a1[31:0], a0[31:0]};
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (outs_or() !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: some output nonzero (we=%b addr=%0d), required all 0", o_sram_we, o_sram_addr);
        end
        i_rst = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (o_sram_we !== 1'b0 || o_proc_counter !== 32'd0 || o_done !== 1'b0) begin
            bad++; $display("FAIL idle_quiet: we=%b proc=%0d done=%b, required 0 0 0", o_sram_we, o_proc_counter, o_done);
        end
    endtask

    task automatic test_no_cars;
        int nbad = 0;
        i_bg_color = 16'h1234; rom_mode = 1'b0; rom_val0 = 4'd5; rom_val1 = 4'd5;
        set_cars(16'd100, 16'd0, 0, 16'd100, 16'd0, 0);
        run_frame(-1, -1, 1, 45);
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] != 20'(i) || wr_data[i] != 16'h1234 || wr_op[i] != 1'b0) nbad++;
        total++;
        if (wr_addr.size() != 32 || nbad !== 0) begin
            bad++; $display("FAIL nocar_pixels: writes=%0d wrong=%0d, required 32 and 0", wr_addr.size(), nbad);
        end
        total++;
        if (first_we !== 3) begin bad++; $display("FAIL first_we_cycle: got %0d, required 3", first_we); end
        total++;
        if (done_cyc !== 35 || done_cnt !== 1) begin
            bad++; $display("FAIL done_timing: cycle=%0d count=%0d, required 35 and 1", done_cyc, done_cnt);
        end
        total++;
        if (o_pixel_counter !== 32'd32 || o_proc_counter !== 32'd34) begin
            bad++; $display("FAIL nocar_counters: pixels=%0d proc=%0d, required 32 and 34", o_pixel_counter, o_proc_counter);
        end
        total++;
        if (opv_bad !== 0 || o_angle_err !== 1'b0) begin
            bad++; $display("FAIL opacity_valid_err: opv_bad=%0d err=%b, required 0 and 0", opv_bad, o_angle_err);
        end
    endtask

    task automatic test_overlap;
        int nbad = 0;
        int x;
        logic [15:0] e;
        i_bg_color = BG; rom_mode = 1'b0; rom_val0 = 4'd5; rom_val1 = 4'd7;
        set_cars(16'd0, 16'd0, 0, 16'd2, 16'd0, 0);
        run_frame(-1, -1, 1, 45);
        for (int i = 0; i < wr_addr.size(); i++) begin
            x = i % 8;
            e = (x < 4) ? P5 : (x < 6) ? P7 : BG;
            if (wr_addr[i] != 20'(i) || wr_data[i] != e || wr_op[i] != (x < 6)) nbad++;
        end
        total++;
        if (wr_addr.size() != 32 || nbad !== 0) begin
            bad++; $display("FAIL overlap_priority: writes=%0d wrong=%0d, required 32 and 0", wr_addr.size(), nbad);
        end
    endtask

    task automatic test_clip;
        int nbad = 0;
        int x, y;
        logic in_spr;
        rom_mode = 1'b0; rom_val0 = 4'd5; rom_val1 = 4'd5;
        set_cars(16'd6, 16'd2, 0, 16'd100, 16'd100, 0);
        run_frame(-1, -1, 1, 45);
        for (int i = 0; i < wr_addr.size(); i++) begin
            x = i % 8; y = i / 8;
            in_spr = (x >= 6) && (y >= 2);
            if (wr_data[i] != (in_spr ? P5 : BG) || wr_op[i] != in_spr) nbad++;
        end
        total++;
        if (wr_addr.size() != 32 || nbad !== 0) begin
            bad++; $display("FAIL edge_clip: writes=%0d wrong=%0d, required 32 and 0", wr_addr.size(), nbad);
        end
    endtask

    task automatic test_angle;
        int ops = 0;
        rom_mode = 1'b0; rom_val0 = 4'd0; rom_val1 = 4'd0;
        set_cars(16'd0, 16'd0, -90, 16'd0, 16'd0, 405);
        run_frame(-1, -1, 1, 45);
        total++;
        if (spr0 !== 7'd96) begin bad++; $display("FAIL bank_neg90: addr=%0d, required 96", spr0); end
        total++;
        if (spr1 !== 7'd16) begin bad++; $display("FAIL bank_405: addr=%0d, required 16", spr1); end
        total++;
        if (o_angle_err !== 1'b0) begin bad++; $display("FAIL err_in_range: err=%b, required 0", o_angle_err); end
        foreach (wr_op[i]) if (wr_op[i]) ops++;
        total++;
        if (ops !== 0 || wr_addr.size() != 32) begin
            bad++; $display("FAIL transparent: opaque=%0d writes=%0d, required 0 and 32", ops, wr_addr.size());
        end
        set_cars(16'd0, 16'd0, 800, 16'd0, 16'd0, 719);
        run_frame(-1, -1, 1, 45);
        total++;
        if (spr0 !== 7'd0 || spr1 !== 7'd112) begin
            bad++; $display("FAIL bank_800_719: addr0=%0d addr1=%0d, required 0 and 112", spr0, spr1);
        end
        total++;
        if (o_angle_err !== 1'b1) begin bad++; $display("FAIL err_sticky: err=%b, required 1", o_angle_err); end
    endtask

    task automatic test_backpressure;
        int nbad = 0;
        int x;
        logic [15:0] e;
        rom_mode = 1'b1;
        set_cars(16'd0, 16'd0, 0, 16'd100, 16'd100, 0);
        run_frame(10, -1, 1, 50);
        for (int i = 0; i < wr_addr.size(); i++) begin
            x = i % 8;
            e = (x < 4) ? pal(x + 1) : BG;
            if (wr_addr[i] != 20'(i) || wr_data[i] != e || wr_op[i] != (x < 4)) nbad++;
        end
        total++;
        if (wr_addr.size() != 32 || nbad !== 0) begin
            bad++; $display("FAIL stall_stream: writes=%0d wrong=%0d, required 32 and 0", wr_addr.size(), nbad);
        end
        total++;
        if (hold_cnt !== 4) begin bad++; $display("FAIL stall_hold: addr10 shown %0d cycles, required 4", hold_cnt); end
        total++;
        if (o_proc_counter !== 32'd37 || o_pixel_counter !== 32'd32 || done_cyc !== 38) begin
            bad++; $display("FAIL stall_counters: proc=%0d pixels=%0d done=%0d, required 37 32 38",
                            o_proc_counter, o_pixel_counter, done_cyc);
        end
        total++;
        if (o_angle_err !== 1'b0) begin bad++; $display("FAIL err_cleared: err=%b, required 0", o_angle_err); end
    endtask

    task automatic test_reset_mid;
        int nbad = 0;
        rom_mode = 1'b0; rom_val0 = 4'd5; rom_val1 = 4'd5;
        set_cars(16'd100, 16'd0, 0, 16'd100, 16'd0, 0);
        run_frame(-1, 17, 1, 45);
        total++;
        if (rst_cyc < 0 || post_rst_any !== 1'b0) begin
            bad++; $display("FAIL midframe_reset: reset_cycle=%0d any_output=%b, required >=0 and 0", rst_cyc, post_rst_any);
        end
        total++;
        if (done_cnt !== 0) begin bad++; $display("FAIL reset_no_done: done pulses=%0d, required 0", done_cnt); end
        run_frame(-1, -1, 1, 45);
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] != 20'(i) || wr_data[i] != BG) nbad++;
        total++;
        if (wr_addr.size() != 32 || nbad !== 0 || done_cyc !== 35) begin
            bad++; $display("FAIL after_reset_frame: writes=%0d wrong=%0d done=%0d, required 32 0 35",
                            wr_addr.size(), nbad, done_cyc);
        end
    endtask

    task automatic test_start_held;
        run_frame(-1, -1, 100, 110);
        total++;
        if (done_cnt !== 1 || wr_addr.size() != 32) begin
            bad++; $display("FAIL start_held: done pulses=%0d writes=%0d, required 1 and 32", done_cnt, wr_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_no_cars();
        test_overlap();
        test_clip();
        test_angle();
        test_backpressure();
        test_reset_mid();
        test_start_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
